// File: rtl/trojan_bench_pkg.sv
// Shared types and constants for the subcircuit pattern driver and its MISR.
package trojan_bench_pkg;

  // Run sequencing: IDLE -> RUN (issue vectors) -> FLUSH (drain latency) -> DONE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Fibonacci LFSR taps (x^16 + x^14 + x^13 + x^11 + 1), bit indices of a 16-bit register.
  localparam int LFSR_TAP_A = 15;
  localparam int LFSR_TAP_B = 13;
  localparam int LFSR_TAP_C = 12;
  localparam int LFSR_TAP_D = 10;

  // Default Galois feedback for the response compactor.
  localparam logic [15:0] DEF_MISR_POLY = 16'h002D;

  // Width of the flush-phase counter; LATENCY is limited to 0..7.
  localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/bench_misr.sv
// Galois MISR folding a 1-bit response stream into a signature.
// clr has priority over en; the register only moves when en is high.
module bench_misr
  import trojan_bench_pkg::*;
#(
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEF_MISR_POLY)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              d_in,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] r_sig;
  logic [MISR_W-1:0] w_next;

  // Next signature: shift left, fold the MSB back through the taps, xor the response into bit 0.
  always_comb begin
    w_next = {r_sig[MISR_W-2:0], 1'b0}
           ^ (r_sig[MISR_W-1] ? MISR_POLY : '0)
           ^ {{(MISR_W-1){1'b0}}, d_in};
  end

  // Signature register: cleared at the start of every run, updated only on valid responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (clr) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= w_next;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/subckt_pattern_driver.sv
// Stimulus/response harness for one extracted subcircuit: an LFSR drives pat_out,
// a valid pipe of depth LATENCY tracks which responses belong to issued vectors,
// and a MISR compacts those responses into a signature checked against GOLDEN_SIG.
//
// Control protocol: start is a level sampled only in IDLE or DONE; a sampled start
// reloads the run and is otherwise ignored. busy covers RUN and FLUSH, done covers
// DONE, and pass/signature are stable and meaningful whenever done is high.
module subckt_pattern_driver
  import trojan_bench_pkg::*;
#(
  parameter int                N_IN       = 5,
  parameter int                LFSR_W     = 16,
  parameter int                MISR_W     = 16,
  parameter int                N_PATTERNS = 1000,
  parameter int                LATENCY    = 2,
  parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(1),
  parameter logic [MISR_W-1:0] MISR_POLY  = MISR_W'(DEF_MISR_POLY),
  parameter logic [MISR_W-1:0] GOLDEN_SIG = '0
) (
  input  logic              I1470_clk,
  input  logic              I1477_rst,
  input  logic              start,
  input  logic              resp_in,
  output logic [N_IN-1:0]   pat_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [15:0]       pat_count,
  output state_e            o_dbg_state
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0]      SEED_EFF   = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [15:0]            LAST_CNT   = 16'(N_PATTERNS - 1);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(LATENCY);

  state_e                  r_state;
  state_e                  w_next_state;
  logic                    w_load;
  logic                    w_run;
  logic                    w_vld_out;
  logic                    w_fb;
  logic [LFSR_W-1:0]       r_lfsr;
  logic [15:0]             r_pat_count;
  logic [FLUSH_CNT_W-1:0]  r_flush_cnt;
  logic                    r_pass;
  logic [MISR_W-1:0]       w_sig;

  assign w_run = (r_state == RUN);
  assign w_fb  = r_lfsr[LFSR_TAP_A] ^ r_lfsr[LFSR_TAP_B] ^ r_lfsr[LFSR_TAP_C] ^ r_lfsr[LFSR_TAP_D];

  // State register.
  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; w_load marks the edge that (re)starts a run.
  // FLUSH lasts LATENCY+1 edges so the last response is folded in before pass is registered.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = RUN;
          w_load       = 1'b1;
        end
      end
      RUN: begin
        if (r_pat_count == LAST_CNT) begin
          w_next_state = FLUSH;
        end
      end
      FLUSH: begin
        if (r_flush_cnt == FLUSH_LAST) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_next_state = RUN;
          w_load       = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Flush-phase edge counter, parked at zero outside FLUSH.
  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      r_flush_cnt <= '0;
    end else if (r_state == FLUSH) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end else begin
      r_flush_cnt <= '0;
    end
  end

  // Pattern generator, vector counter and registered verdict.
  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      r_lfsr      <= SEED_EFF;
      r_pat_count <= '0;
      r_pass      <= 1'b0;
    end else if (w_load) begin
      r_lfsr      <= SEED_EFF;
      r_pat_count <= '0;
      r_pass      <= 1'b0;
    end else if (w_run) begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
      if (r_pat_count != 16'hFFFF) begin
        r_pat_count <= r_pat_count + 16'd1;
      end
    end else if ((r_state == FLUSH) && (w_next_state == DONE)) begin
      r_pass <= (w_sig == GOLDEN_SIG);
    end
  end

  // Valid pipe: a 1 enters for every issued vector and emerges when its response arrives.
  generate
    if (LATENCY == 0) begin : g_no_pipe
      assign w_vld_out = w_run;
    end else begin : g_pipe
      logic [LATENCY-1:0] r_pipe;

      // Shift in "vector issued this cycle"; cleared on reload.
      always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
          r_pipe <= '0;
        end else if (w_load) begin
          r_pipe <= '0;
        end else begin
          r_pipe <= (r_pipe << 1) | LATENCY'(w_run);
        end
      end

      assign w_vld_out = r_pipe[LATENCY-1];
    end
  endgenerate

  bench_misr #(
    .MISR_W   (MISR_W),
    .MISR_POLY(MISR_POLY)
  ) u_misr (
    .clk  (I1470_clk),
    .rst_n(I1477_rst),
    .clr  (w_load),
    .en   (w_vld_out),
    .d_in (resp_in),
    .sig  (w_sig)
  );

  assign pat_out     = r_lfsr[N_IN-1:0];
  assign busy        = (r_state == RUN) || (r_state == FLUSH);
  assign done        = (r_state == DONE);
  assign pass        = r_pass;
  assign signature   = w_sig;
  assign pat_count   = r_pat_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_subckt_pattern_driver.sv
// Bench for subckt_pattern_driver: three configurations (N=4/L=2, N=1/L=0,
// N=1000/L=2 driving a 2-flop subcircuit model). Drivers push expected
// results into queues; monitors pop and compare when done rises / vectors appear.
module tb_subckt_pattern_driver;
  import trojan_bench_pkg::*;

  localparam int RW = 49; // {sig[15:0], pass, pat_count[15:0], edges[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT signals ----------------
  logic        start_a = 0, start_b = 0, start_c = 0;
  logic        resp_a = 0, resp_b = 0;
  logic [4:0]  pat_a, pat_b, pat_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
  logic [15:0] sig_a, sig_b, sig_c, cnt_a, cnt_b, cnt_c;
  state_e      dbg_a, dbg_b, dbg_c;

  subckt_pattern_driver #(.N_PATTERNS(4), .LATENCY(2), .SEED(16'h0001), .GOLDEN_SIG(16'h0000)) dut_a (
    .I1470_clk(clk), .I1477_rst(rst_n), .start(start_a), .resp_in(resp_a),
    .pat_out(pat_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .pat_count(cnt_a), .o_dbg_state(dbg_a));

  subckt_pattern_driver #(.N_PATTERNS(1), .LATENCY(0)) dut_b (
    .I1470_clk(clk), .I1477_rst(rst_n), .start(start_b), .resp_in(resp_b),
    .pat_out(pat_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .pat_count(cnt_b), .o_dbg_state(dbg_b));

  // Subcircuit model: 5 inputs, two flop stages, optional flipped gate.
  bit   trojan = 0;
  logic r1a = 0, r1b = 0, resp_c = 0;
  always @(posedge clk) begin
    r1a    <= pat_c[0] ^ pat_c[1];
    r1b    <= trojan ? (pat_c[2] | pat_c[3] | pat_c[4]) : ((pat_c[2] & pat_c[3]) | pat_c[4]);
    resp_c <= r1a ^ r1b;
  end

  subckt_pattern_driver #(.N_PATTERNS(1000), .LATENCY(2)) dut_c (
    .I1470_clk(clk), .I1477_rst(rst_n), .start(start_c), .resp_in(resp_c),
    .pat_out(pat_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .signature(sig_c), .pat_count(cnt_c), .o_dbg_state(dbg_c));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0] exp_a_q[$];
  logic [RW-1:0] exp_b_q[$];
  logic [RW-1:0] exp_c_q[$];
  logic [4:0]    pat_q[$];
  int start_cyc_a = 0, start_cyc_b = 0, start_cyc_c = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: event missing", name);
  endtask

  function automatic logic [RW-1:0] mk_exp(input logic [15:0] s, input logic p,
                                           input logic [15:0] c, input logic [15:0] e);
    return {s, p, c, e};
  endfunction

  // Reference model: subcircuit function, LFSR and MISR as defined for the block.
  function automatic logic subckt_f(input logic [4:0] p, input bit troj);
    return (p[0] ^ p[1]) ^ (troj ? (p[2] | p[3] | p[4]) : ((p[2] & p[3]) | p[4]));
  endfunction

  function automatic logic [15:0] model_sig(input int n, input bit troj);
    logic [15:0] l, m;
    logic        fb;
    l = 16'h0001;
    m = 16'h0000;
    for (int i = 0; i < n; i++) begin
      m  = {m[14:0], 1'b0} ^ (m[15] ? 16'h002D : 16'h0000) ^ {15'b0, subckt_f(l[4:0], troj)};
      fb = l[15] ^ l[13] ^ l[12] ^ l[10];
      l  = {l[14:0], fb};
    end
    return m;
  endfunction

  task automatic compare_result(input string tag, input logic [RW-1:0] e, input logic [15:0] s,
                                input logic p, input logic [15:0] c, input int edges);
    check({tag, "_sig"},   s, e[48:33]);
    check({tag, "_pass"},  p, e[32]);
    check({tag, "_count"}, c, e[31:16]);
    check({tag, "_done_edges"}, 16'(edges), e[15:0]);
  endtask

  // Result monitors: compare on every rising edge of done.
  logic prev_done_a = 0, prev_done_b = 0, prev_done_c = 0;
  always @(negedge clk) begin
    if (done_a && !prev_done_a) begin
      if (exp_a_q.size() == 0) fail("a_done_unexpected");
      else compare_result("a", exp_a_q.pop_front(), sig_a, pass_a, cnt_a, cyc - start_cyc_a);
    end
    prev_done_a = done_a;
  end
  always @(negedge clk) begin
    if (done_b && !prev_done_b) begin
      if (exp_b_q.size() == 0) fail("b_done_unexpected");
      else compare_result("b", exp_b_q.pop_front(), sig_b, pass_b, cnt_b, cyc - start_cyc_b);
    end
    prev_done_b = done_b;
  end
  always @(negedge clk) begin
    if (done_c && !prev_done_c) begin
      if (exp_c_q.size() == 0) fail("c_done_unexpected");
      else compare_result("c", exp_c_q.pop_front(), sig_c, pass_c, cnt_c, cyc - start_cyc_c);
    end
    prev_done_c = done_c;
  end

  // Vector monitor for dut_a: one expected pattern per RUN cycle.
  always @(negedge clk) begin
    if (rst_n && dbg_a == RUN) begin
      if (pat_q.size() == 0) fail("a_pat_unexpected");
      else check("a_pat", pat_a, pat_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic pulse_start(input int which);
    @(posedge clk); #1 set_start(which, 1'b1);
    @(posedge clk); #1 set_start(which, 1'b0);
    case (which)
      0:       start_cyc_a = cyc;
      1:       start_cyc_b = cyc;
      default: start_cyc_c = cyc;
    endcase
  endtask

  function automatic logic done_of(input int which);
    case (which)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic wait_done(input int which, input int budget);
    int n = 0;
    while (!done_of(which) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done_of(which)) fail($sformatf("done_timeout_%0d", which));
  endtask

  task automatic push_pats4();
    pat_q.push_back(5'h01);
    pat_q.push_back(5'h02);
    pat_q.push_back(5'h04);
    pat_q.push_back(5'h08);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] exp_clean, exp_troj;

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_state", dbg_a, IDLE);
    check("rst_busy",  busy_a, 1'b0);
    check("rst_done",  done_a, 1'b0);
    check("rst_pass",  pass_a, 1'b0);
    check("rst_sig",   sig_a, 16'h0000);
    check("rst_pat",   pat_a, 5'h01);
    check("rst_cnt",   cnt_a, 16'h0000);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset asserted mid-RUN after one MISR update.
    resp_a = 1'b1;
    pat_q.push_back(5'h01);
    pat_q.push_back(5'h02);
    pat_q.push_back(5'h04);
    pulse_start(0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrun_rst_state", dbg_a, IDLE);
    check("midrun_rst_busy",  busy_a, 1'b0);
    check("midrun_rst_sig",   sig_a, 16'h0000);
    check("midrun_rst_pat",   pat_a, 5'h01);
    check("midrun_rst_cnt",   cnt_a, 16'h0000);
    @(posedge clk); #1 rst_n = 1'b1;

    // N=4, resp=0: patterns 01,02,04,08, signature 0, pass.
    resp_a = 1'b0;
    push_pats4();
    exp_a_q.push_back(mk_exp(16'h0000, 1'b1, 16'd4, 16'd7));
    pulse_start(0);
    wait_done(0, 50);
    repeat (2) @(negedge clk);

    // N=4, resp=1 restarted from DONE: signature F, fail.
    resp_a = 1'b1;
    push_pats4();
    exp_a_q.push_back(mk_exp(16'h000F, 1'b0, 16'd4, 16'd7));
    pulse_start(0);
    wait_done(0, 50);
    repeat (2) @(negedge clk);

    // start held through RUN: no retrigger, then a pulse in DONE repeats the signature.
    push_pats4();
    exp_a_q.push_back(mk_exp(16'h000F, 1'b0, 16'd4, 16'd7));
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_cyc_a = cyc;
    repeat (4) @(posedge clk);
    #1 start_a = 1'b0;
    wait_done(0, 50);
    repeat (3) @(negedge clk);
    check("held_done_stays", done_a, 1'b1);
    check("held_state",      dbg_a, DONE);
    check("held_cnt",        cnt_a, 16'd4);
    push_pats4();
    exp_a_q.push_back(mk_exp(16'h000F, 1'b0, 16'd4, 16'd7));
    pulse_start(0);
    wait_done(0, 50);

    // LATENCY=0, N=1, resp=1: single update, done two edges after start.
    resp_b = 1'b1;
    exp_b_q.push_back(mk_exp(16'h0001, 1'b0, 16'd1, 16'd2));
    pulse_start(1);
    wait_done(1, 20);

    // 1000 vectors through the 2-flop subcircuit, clean then with one gate flipped.
    exp_clean = model_sig(1000, 1'b0);
    exp_troj  = model_sig(1000, 1'b1);
    exp_c_q.push_back(mk_exp(exp_clean, exp_clean == 16'h0000, 16'd1000, 16'd1003));
    pulse_start(2);
    wait_done(2, 1100);
    repeat (2) @(negedge clk);
    trojan = 1'b1;
    exp_c_q.push_back(mk_exp(exp_troj, exp_troj == 16'h0000, 16'd1000, 16'd1003));
    pulse_start(2);
    wait_done(2, 1100);
    repeat (2) @(negedge clk);

    check("pat_q_drained", pat_q.size(), 0);
    check("a_q_drained",   exp_a_q.size(), 0);
    check("b_q_drained",   exp_b_q.size(), 0);
    check("c_q_drained",   exp_c_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
